sprite_sequencer: RTL
=====================

SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

Interface
REQ-001 SHALL have parameter CORDW, default 10, meaning screen coordinate width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning sprite table depth (power of two).
REQ-003 SHALL have parameter SPR_IDW, default 4, meaning sprite image selector width.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to draw the table.
REQ-007 SHALL have port wr_en  input  1  table write strobe.
REQ-008 SHALL have port wr_idx  input  $clog2(ENTRIES)  table entry written.
REQ-009 SHALL have ports wr_x, wr_y  input  CORDW each  sprite screen position.
REQ-010 SHALL have port wr_scale  input  8  scaling byte, passed through unmodified.
REQ-011 SHALL have port wr_id  input  SPR_IDW  sprite image selector.
REQ-012 SHALL have port wr_valid  input  1  entry is to be drawn.
REQ-013 SHALL have ports rnd_sx, rnd_sy  output  CORDW each  position to renderer.
REQ-014 SHALL have port rnd_scale  output  8  scale to renderer.
REQ-015 SHALL have port rnd_id  output  SPR_IDW  image selector to sprite ROM mux.
REQ-016 SHALL have port rnd_rst  output  1  renderer reset pulse.
REQ-017 SHALL have port rnd_enable  output  1  renderer enable.
REQ-018 SHALL have port rnd_finished  input  1  renderer completion flag (level).
REQ-019 SHALL have ports busy  output  1  (state not IDLE) and done  output  1  (single-cycle completion pulse).

Function
REQ-020 Table SHALL hold ENTRIES registers of {x, y, scale, id, valid}; a write with wr_en=1 SHALL update entry wr_idx at that clock edge, in any state.
REQ-021 FSM states SHALL be IDLE, FETCH, LOAD, DRAW, NEXT, DONE.
REQ-022 IDLE: start=1 -> FETCH with idx=0 on the next cycle; start in any other state SHALL be ignored.
REQ-023 FETCH: if entry[idx].valid=1 and scale!=0, latch x, y, scale, id into rnd_* and go to LOAD; otherwise go to NEXT with rnd_* unchanged.
REQ-024 FETCH SHALL read the table value before any same-cycle write to entry idx (the write is seen only on a later pass).
REQ-025 LOAD: rnd_rst=1 for exactly one cycle, rnd_enable=0; then DRAW.
REQ-026 DRAW: rnd_enable=1 each cycle; when rnd_finished=1 is sampled, go to NEXT, so rnd_enable is low from the following cycle.
REQ-027 NEXT: idx=ENTRIES-1 -> DONE; else idx+1 -> FETCH; idx SHALL NOT wrap to continue drawing.
REQ-028 DONE: done=1 for one cycle, then IDLE.
REQ-029 rnd_* outputs SHALL hold their latched values from FETCH through the end of DRAW, regardless of table writes.
REQ-030 Per drawn entry, overhead outside DRAW SHALL be 3 cycles (FETCH, LOAD, NEXT); per skipped entry, 2 cycles (FETCH, NEXT).
REQ-031 An all-invalid table SHALL complete in 2*ENTRIES+1 cycles from start to the done pulse, with rnd_enable never high.
REQ-032 busy SHALL be 1 in every state except IDLE, including DONE.

Reset
REQ-033 While rst=1, state SHALL go to IDLE, idx=0, all table valid bits=0, rnd_sx=rnd_sy=0, rnd_scale=0, rnd_id=0, rnd_enable=0, busy=0, done=0.
REQ-034 rnd_rst SHALL be driven high combinationally while rst=1, so the renderer is also reset.
REQ-035 rst asserted mid-DRAW SHALL abort the pass; no done pulse is produced for the aborted pass.
REQ-036 Table x, y, scale, and id fields need not be reset.

Verification
REQ-037 Write entry 0={x=100,y=50,scale=0x10,id=3,valid=1}, others invalid, pulse start; renderer model finishes after 256 cycles -> one rnd_rst pulse; rnd_enable high for 256+1 cycles with rnd_sx=100, rnd_sy=50, rnd_id=3; done fires once.
REQ-038 Empty table, start -> done exactly 33 cycles after start with ENTRIES=16; rnd_enable and rnd_rst stay 0.
REQ-039 Entries 2, 5, and 15 valid -> three DRAW phases in index order 2, 5, 15; each preceded by a one-cycle rnd_rst.
REQ-040 Valid entry with scale=0 -> skipped, with no rnd_rst and no rnd_enable.
REQ-041 During DRAW of entry 5, write entry 5 with x=700 -> rnd_sx unchanged until NEXT; a second pass draws at x=700; start during busy has no effect.
REQ-042 Assert rst for one cycle mid-DRAW -> next cycle IDLE, outputs at reset values, rnd_rst high during rst, no done pulse, and a subsequent start draws nothing (valid bits cleared).

Source files
------------

// File: rtl/sprite_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_sequencer
// Brief    : Walks a sprite table in index order and drives a sprite renderer.
// Revision : 1.0
// ============================================================================
module sprite_sequencer #(
    parameter int CORDW   = 10,
    parameter int ENTRIES = 16,
    parameter int SPR_IDW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wr_en,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  logic [CORDW-1:0]           wr_x,
    input  logic [CORDW-1:0]           wr_y,
    input  logic [7:0]                 wr_scale,
    input  logic [SPR_IDW-1:0]         wr_id,
    input  logic                       wr_valid,
    output logic [CORDW-1:0]           rnd_sx,
    output logic [CORDW-1:0]           rnd_sy,
    output logic [7:0]                 rnd_scale,
    output logic [SPR_IDW-1:0]         rnd_id,
    output logic                       rnd_rst,
    output logic                       rnd_enable,
    input  logic                       rnd_finished,
    output logic                       busy,
    output logic                       done
);

    localparam int              IDXW       = $clog2(ENTRIES);
    localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAW  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state_q,   w_state_d;
    logic [IDXW-1:0]      r_idx_q,     w_idx_d;
    logic [CORDW-1:0]     r_sx_q,      w_sx_d;
    logic [CORDW-1:0]     r_sy_q,      w_sy_d;
    logic [7:0]           r_scale_q,   w_scale_d;
    logic [SPR_IDW-1:0]   r_id_q,      w_id_d;
    logic                 r_rnd_rst_q, w_rnd_rst_d;
    logic                 r_enable_q,  w_enable_d;
    logic                 r_busy_q,    w_busy_d;
    logic                 r_done_q,    w_done_d;

    logic [CORDW-1:0]     r_tab_x_q     [ENTRIES];
    logic [CORDW-1:0]     w_tab_x_d     [ENTRIES];
    logic [CORDW-1:0]     r_tab_y_q     [ENTRIES];
    logic [CORDW-1:0]     w_tab_y_d     [ENTRIES];
    logic [7:0]           r_tab_scale_q [ENTRIES];
    logic [7:0]           w_tab_scale_d [ENTRIES];
    logic [SPR_IDW-1:0]   r_tab_id_q    [ENTRIES];
    logic [SPR_IDW-1:0]   w_tab_id_d    [ENTRIES];
    logic [ENTRIES-1:0]   r_tab_valid_q, w_tab_valid_d;

    logic                 w_fetch_hit;

    // Table is read from the registered copy, so a same-cycle write is only seen later
    assign w_fetch_hit = r_tab_valid_q[r_idx_q] && (r_tab_scale_q[r_idx_q] != 8'd0);

    always_comb begin
        w_tab_x_d     = r_tab_x_q;
        w_tab_y_d     = r_tab_y_q;
        w_tab_scale_d = r_tab_scale_q;
        w_tab_id_d    = r_tab_id_q;
        w_tab_valid_d = r_tab_valid_q;
        if (wr_en) begin
            w_tab_x_d[wr_idx]     = wr_x;
            w_tab_y_d[wr_idx]     = wr_y;
            w_tab_scale_d[wr_idx] = wr_scale;
            w_tab_id_d[wr_idx]    = wr_id;
            w_tab_valid_d[wr_idx] = wr_valid;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_sx_d      = r_sx_q;
        w_sy_d      = r_sy_q;
        w_scale_d   = r_scale_q;
        w_id_d      = r_id_q;
        w_rnd_rst_d = 1'b0;
        w_enable_d  = 1'b0;
        w_done_d    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_FETCH;
                    w_idx_d   = '0;
                end
            end
            S_FETCH: begin
                if (w_fetch_hit) begin
                    w_sx_d      = r_tab_x_q[r_idx_q];
                    w_sy_d      = r_tab_y_q[r_idx_q];
                    w_scale_d   = r_tab_scale_q[r_idx_q];
                    w_id_d      = r_tab_id_q[r_idx_q];
                    w_rnd_rst_d = 1'b1;
                    w_state_d   = S_LOAD;
                end else begin
                    w_state_d = S_NEXT;
                end
            end
            S_LOAD: begin
                w_enable_d = 1'b1;
                w_state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (rnd_finished) begin
                    w_state_d = S_NEXT;
                end else begin
                    w_enable_d = 1'b1;
                end
            end
            S_NEXT: begin
                if (r_idx_q == c_IDX_LAST) begin
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_idx_d   = r_idx_q + 1'b1;
                    w_state_d = S_FETCH;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        r_tab_x_q     <= w_tab_x_d;
        r_tab_y_q     <= w_tab_y_d;
        r_tab_scale_q <= w_tab_scale_d;
        r_tab_id_q    <= w_tab_id_d;
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_idx_q       <= '0;
            r_sx_q        <= '0;
            r_sy_q        <= '0;
            r_scale_q     <= '0;
            r_id_q        <= '0;
            r_rnd_rst_q   <= 1'b0;
            r_enable_q    <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_tab_valid_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_sx_q        <= w_sx_d;
            r_sy_q        <= w_sy_d;
            r_scale_q     <= w_scale_d;
            r_id_q        <= w_id_d;
            r_rnd_rst_q   <= w_rnd_rst_d;
            r_enable_q    <= w_enable_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
            r_tab_valid_q <= w_tab_valid_d;
        end
    end

    // The renderer shares our reset so it never runs with stale state
    assign rnd_rst    = r_rnd_rst_q | rst;
    assign rnd_sx     = r_sx_q;
    assign rnd_sy     = r_sy_q;
    assign rnd_scale  = r_scale_q;
    assign rnd_id     = r_id_q;
    assign rnd_enable = r_enable_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire
